wb_dcache: RTL and testbench



---
 rtl/wb_dcache.sv | 235 +++++++++++++++++++++++
 tb/tb_wb_dcache.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dcache.sv
// Direct-mapped, write-back, write-allocate data cache between a CPU Wishbone
// port and a burst-capable memory Wishbone port. 16 lines x 32 words.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a CPU request; latches address/data/sel
// TAG_RD   | tag entry for the request index is read into tag_q
// CMP      | tag compare; hit updates/reads the array, miss starts bursts
// ACK      | one-cycle CPU acknowledge
// TURN     | one-cycle turnaround, CPU strobe ignored
// WB_BURST | dirty victim written back, one word per app ack
// FILL     | line refilled from memory, then lookup is repeated
// ERR      | one-cycle CPU error pulse after an aborted burst
module wb_dcache #(
  parameter int WB_AW      = 32,
  parameter int WB_DW      = 32,
  parameter int TAG_MEM_WD = 22,
  parameter int TAG_MEM_DP = 16,
  parameter int CACHELINES = 16,
  parameter int CACHESIZE  = 32
) (
  input  logic               mclk,
  input  logic               rst_n,
  input  logic               wb_cpu_stb_i,
  input  logic [WB_AW-1:0]   wb_cpu_adr_i,
  input  logic               wb_cpu_we_i,
  input  logic [WB_DW-1:0]   wb_cpu_dat_i,
  input  logic [WB_DW/8-1:0] wb_cpu_sel_i,
  output logic [WB_DW-1:0]   wb_cpu_dat_o,
  output logic               wb_cpu_ack_o,
  output logic               wb_cpu_err_o,
  output logic               wb_app_stb_o,
  output logic [WB_AW-1:0]   wb_app_adr_o,
  output logic               wb_app_we_o,
  output logic [WB_DW-1:0]   wb_app_dat_o,
  output logic [WB_DW/8-1:0] wb_app_sel_o,
  output logic [7:0]         wb_app_bl_o,
  input  logic [WB_DW-1:0]   wb_app_dat_i,
  input  logic               wb_app_ack_i,
  input  logic               wb_app_lack_i,
  input  logic               wb_app_err_i
);

  localparam int SEL_W   = WB_DW / 8;
  localparam int OFS_W   = $clog2(CACHESIZE);
  localparam int IDX_W   = $clog2(CACHELINES);
  localparam int TAG_W   = TAG_MEM_WD - 1;
  localparam int IDX_LSB = OFS_W + 2;
  localparam int TAG_LSB = IDX_LSB + IDX_W;

  typedef enum logic [2:0] {
    IDLE, TAG_RD, CMP, ACK, TURN, WB_BURST, FILL, ERR
  } state_t;

  state_t state, state_nxt;

  logic [WB_DW-1:0]      data_mem [CACHELINES*CACHESIZE];
  logic [TAG_MEM_WD-1:0] tag_mem  [TAG_MEM_DP];
  logic [CACHELINES-1:0] dirty;

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [OFS_W-1:0]      req_ofs;
  logic                  req_we;
  logic [WB_DW-1:0]      req_dat;
  logic [SEL_W-1:0]      req_sel;
  logic [TAG_MEM_WD-1:0] tag_q;
  logic [OFS_W-1:0]      beat;
  logic [OFS_W-1:0]      beat_inc;

  logic hit, victim_dirty;
  logic app_ack_v, app_lack_v, app_err_v, beat_v;

  logic [SEL_W-1:0]       mem_we;
  logic [IDX_W+OFS_W-1:0] mem_waddr;
  logic [WB_DW-1:0]       mem_wdata;

  logic unused_adr;

  // Low address bits select bytes, which sel already covers.
  assign unused_adr = ^wb_cpu_adr_i[1:0];

  assign hit          = tag_q[TAG_W] && (tag_q[TAG_W-1:0] == req_tag);
  assign victim_dirty = tag_q[TAG_W] && dirty[req_idx];
  // App responses only count while a burst is actually requested.
  assign app_ack_v    = wb_app_stb_o && wb_app_ack_i;
  assign app_lack_v   = wb_app_stb_o && wb_app_lack_i;
  assign app_err_v    = wb_app_stb_o && wb_app_err_i;
  assign beat_v       = app_ack_v || app_lack_v;
  assign beat_inc     = beat + 1'b1;

  // State register.
  always_ff @(posedge mclk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (wb_cpu_stb_i) state_nxt = TAG_RD;
      TAG_RD:   state_nxt = CMP;
      CMP: begin
        if (hit)               state_nxt = ACK;
        else if (victim_dirty) state_nxt = WB_BURST;
        else                   state_nxt = FILL;
      end
      WB_BURST: begin
        if (app_err_v)       state_nxt = ERR;
        else if (app_lack_v) state_nxt = FILL;
      end
      FILL: begin
        if (app_err_v)       state_nxt = ERR;
        else if (app_lack_v) state_nxt = TAG_RD;
      end
      ACK:      state_nxt = TURN;
      ERR:      state_nxt = TURN;
      TURN:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Data array write port: write-hit byte merge or refill word.
  always_comb begin
    mem_we    = '0;
    mem_waddr = {req_idx, req_ofs};
    mem_wdata = req_dat;
    if (state == CMP && hit && req_we) begin
      mem_we = req_sel;
    end else if (state == FILL && beat_v && !app_err_v) begin
      mem_we    = '1;
      mem_waddr = {req_idx, beat};
      mem_wdata = wb_app_dat_i;
    end
  end

  // Data array storage with byte enables.
  always_ff @(posedge mclk) begin
    if (rst_n) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (mem_we[b]) data_mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Tag and dirty bookkeeping.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      for (int i = 0; i < TAG_MEM_DP; i++) tag_mem[i] <= '0;
      dirty <= '0;
    end else begin
      if (state == CMP && hit && req_we) dirty[req_idx] <= 1'b1;
      if (state == FILL && app_lack_v && !app_err_v) begin
        tag_mem[req_idx] <= {1'b1, req_tag};
        dirty[req_idx]   <= 1'b0;
      end
      // The array may hold a partial refill, so the line must not hit again.
      if (app_err_v) begin
        tag_mem[req_idx][TAG_W] <= 1'b0;
        dirty[req_idx]          <= 1'b0;
      end
    end
  end

  // Request capture in IDLE and tag read in TAG_RD.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      req_tag <= '0;
      req_idx <= '0;
      req_ofs <= '0;
      req_we  <= 1'b0;
      req_dat <= '0;
      req_sel <= '0;
      tag_q   <= '0;
    end else begin
      if (state == IDLE && wb_cpu_stb_i) begin
        req_tag <= wb_cpu_adr_i[WB_AW-1:TAG_LSB];
        req_idx <= wb_cpu_adr_i[TAG_LSB-1:IDX_LSB];
        req_ofs <= wb_cpu_adr_i[IDX_LSB-1:2];
        req_we  <= wb_cpu_we_i;
        req_dat <= wb_cpu_dat_i;
        req_sel <= wb_cpu_sel_i;
      end
      if (state == TAG_RD) tag_q <= tag_mem[req_idx];
    end
  end

  // App-side burst master. Strobe drops for one cycle after every lack so the
  // writeback and the refill are two distinct bursts.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      wb_app_stb_o <= 1'b0;
      wb_app_adr_o <= '0;
      wb_app_we_o  <= 1'b0;
      wb_app_dat_o <= '0;
      wb_app_sel_o <= '0;
      wb_app_bl_o  <= '0;
      beat         <= '0;
    end else begin
      wb_app_sel_o <= '1;
      wb_app_bl_o  <= 8'(CACHESIZE);
      wb_app_stb_o <= (state_nxt == WB_BURST || state_nxt == FILL) &&
                      !app_lack_v && !app_err_v;
      wb_app_we_o  <= (state_nxt == WB_BURST);
      if (state == CMP && state_nxt == WB_BURST) begin
        wb_app_adr_o <= {tag_q[TAG_W-1:0], req_idx, {IDX_LSB{1'b0}}};
        wb_app_dat_o <= data_mem[{req_idx, {OFS_W{1'b0}}}];
        beat         <= '0;
      end else if (state_nxt == FILL && state != FILL) begin
        wb_app_adr_o <= {req_tag, req_idx, {IDX_LSB{1'b0}}};
        wb_app_dat_o <= '0;
        beat         <= '0;
      end else if (beat_v) begin
        beat <= beat_inc;
        if (state == WB_BURST) wb_app_dat_o <= data_mem[{req_idx, beat_inc}];
      end
    end
  end

  // Registered CPU completion and read data.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      wb_cpu_ack_o <= 1'b0;
      wb_cpu_err_o <= 1'b0;
      wb_cpu_dat_o <= '0;
    end else begin
      wb_cpu_ack_o <= (state_nxt == ACK);
      wb_cpu_err_o <= (state_nxt == ERR);
      if (state == CMP && hit && !req_we) wb_cpu_dat_o <= data_mem[{req_idx, req_ofs}];
      else                                wb_cpu_dat_o <= '0;
    end
  end

endmodule

// File: tb/tb_wb_dcache.sv
// Directed bench for wb_dcache with a burst memory model on the app port.
module tb_wb_dcache;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_stb = 1'b0;
  logic [31:0] cpu_adr = '0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_dat = '0;
  logic [3:0]  cpu_sel = '0;
  logic [31:0] wb_cpu_dat_o;
  logic        wb_cpu_ack_o, wb_cpu_err_o;
  logic        wb_app_stb_o, wb_app_we_o;
  logic [31:0] wb_app_adr_o, wb_app_dat_o;
  logic [3:0]  wb_app_sel_o;
  logic [7:0]  wb_app_bl_o;
  logic [31:0] app_dat = '0;
  logic        app_ack = 1'b0, app_lack = 1'b0, app_err = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem  [logic [31:0]];
  logic [31:0] expw [logic [31:0]];
  logic [31:0] blog_adr [$];
  logic        blog_we  [$];
  logic [31:0] blog_w0  [$];
  logic [7:0]  blog_bl  [$];
  logic        err_inject = 1'b0;
  int          err_beat = 0;

  wb_dcache dut (
    .mclk(mclk), .rst_n(rst_n),
    .wb_cpu_stb_i(cpu_stb), .wb_cpu_adr_i(cpu_adr), .wb_cpu_we_i(cpu_we),
    .wb_cpu_dat_i(cpu_dat), .wb_cpu_sel_i(cpu_sel),
    .wb_cpu_dat_o(wb_cpu_dat_o), .wb_cpu_ack_o(wb_cpu_ack_o), .wb_cpu_err_o(wb_cpu_err_o),
    .wb_app_stb_o(wb_app_stb_o), .wb_app_adr_o(wb_app_adr_o), .wb_app_we_o(wb_app_we_o),
    .wb_app_dat_o(wb_app_dat_o), .wb_app_sel_o(wb_app_sel_o), .wb_app_bl_o(wb_app_bl_o),
    .wb_app_dat_i(app_dat), .wb_app_ack_i(app_ack), .wb_app_lack_i(app_lack),
    .wb_app_err_i(app_err)
  );

  initial forever #5 mclk = ~mclk;

  // Preloaded memory contents, indexed by word address.
  function automatic logic [31:0] pat(input logic [31:0] wa);
    return (wa * 32'h0001_0003) ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] wa);
    return mem.exists(wa) ? mem[wa] : pat(wa);
  endfunction

  // Architectural value of a byte address as seen by the CPU.
  function automatic logic [31:0] arch(input logic [31:0] a);
    return expw.exists(a >> 2) ? expw[a >> 2] : pat(a >> 2);
  endfunction

  // Burst memory: acks every cycle stb is high, lack together with the 32nd ack.
  initial begin
    int sl_beat;
    logic [31:0] wa;
    sl_beat = 0;
    forever begin
      @(posedge mclk); #1;
      app_ack = 1'b0; app_lack = 1'b0; app_err = 1'b0; app_dat = '0;
      if (!rst_n || !wb_app_stb_o) begin
        sl_beat = 0;
      end else begin
        if (sl_beat == 0) begin
          blog_adr.push_back(wb_app_adr_o);
          blog_we.push_back(wb_app_we_o);
          blog_w0.push_back(wb_app_dat_o);
          blog_bl.push_back(wb_app_bl_o);
        end
        wa = {2'b00, wb_app_adr_o[31:2]} + 32'(sl_beat);
        if (err_inject && !wb_app_we_o && sl_beat == err_beat) begin
          app_err = 1'b1;
          err_inject = 1'b0;
          sl_beat = 0;
        end else begin
          if (wb_app_we_o) mem[wa] = wb_app_dat_o;
          else             app_dat = mem_rd(wa);
          app_ack  = 1'b1;
          app_lack = (sl_beat == 31);
          sl_beat  = (sl_beat == 31) ? 0 : sl_beat + 1;
        end
      end
    end
  end

  task automatic clear_log();
    blog_adr.delete(); blog_we.delete(); blog_w0.delete(); blog_bl.delete();
  endtask

  // One CPU access; cyc counts edges from strobe assertion to ack/err.
  task automatic cpu_xfer(input logic [31:0] a, input logic we, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rd,
                          output logic ack, output logic err, output int cyc);
    repeat (2) @(posedge mclk);
    #1;
    cpu_stb = 1'b1; cpu_adr = a; cpu_we = we; cpu_dat = d; cpu_sel = s;
    cyc = 0; ack = 1'b0; err = 1'b0; rd = '0;
    while (!ack && !err && cyc < 400) begin
      @(posedge mclk); #1;
      cyc++;
      ack = wb_cpu_ack_o; err = wb_cpu_err_o; rd = wb_cpu_dat_o;
    end
    cpu_stb = 1'b0; cpu_we = 1'b0;
    if (!ack && !err) begin
      vectors++; miscompares++;
      $display("FAIL cpu_timeout adr=%h no ack/err within %0d cycles", a, cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    vectors++;
    if ({wb_cpu_ack_o, wb_cpu_err_o, wb_cpu_dat_o, wb_app_stb_o, wb_app_adr_o, wb_app_we_o,
         wb_app_dat_o, wb_app_sel_o, wb_app_bl_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs stb=%b adr=%h sel=%h bl=%0d ack=%b, all required 0",
               wb_app_stb_o, wb_app_adr_o, wb_app_sel_o, wb_app_bl_o, wb_cpu_ack_o);
    end
    rst_n = 1'b1;
    @(posedge mclk); #1;
    vectors++;
    if (wb_app_sel_o !== 4'hF || wb_app_bl_o !== 8'd32 || wb_app_stb_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release sel=%h bl=%0d stb=%b, required sel=f bl=32 stb=0",
               wb_app_sel_o, wb_app_bl_o, wb_app_stb_o);
    end
  endtask

  task automatic test_seq_read();
    logic [31:0] a, rd, ladr;
    logic ack, err, lwe;
    logic [7:0] lbl;
    int cyc, nb;
    for (int i = 0; i < 1024; i++) begin
      a = 32'(i) * 4;
      nb = blog_adr.size();
      cpu_xfer(a, 1'b0, 32'h0, 4'h0, rd, ack, err, cyc);
      vectors++;
      if (!ack || rd !== arch(a)) begin
        miscompares++;
        $display("FAIL seq_read adr=%h got=%h ack=%b required=%h", a, rd, ack, arch(a));
      end
      vectors++;
      if (i % 32 == 0) begin
        ladr = (blog_adr.size() == nb + 1) ? blog_adr[nb] : 32'hFFFF_FFFF;
        lwe  = (blog_we.size()  == nb + 1) ? blog_we[nb]  : 1'b1;
        lbl  = (blog_bl.size()  == nb + 1) ? blog_bl[nb]  : 8'hFF;
        if (blog_adr.size() != nb + 1 || ladr !== {a[31:7], 7'b0} || lwe !== 1'b0 || lbl !== 8'd32) begin
          miscompares++;
          $display("FAIL seq_refill adr=%h bursts=%0d burst_adr=%h we=%b bl=%0d, required 1 read burst at %h bl=32",
                   a, blog_adr.size() - nb, ladr, lwe, lbl, {a[31:7], 7'b0});
        end
      end else if (cyc != 3 || blog_adr.size() != nb) begin
        miscompares++;
        $display("FAIL seq_hit adr=%h latency=%0d bursts=%0d, required latency=3 bursts=0",
                 a, cyc, blog_adr.size() - nb);
      end
    end
  endtask

  task automatic test_random_read();
    logic [31:0] a, rd;
    logic ack, err;
    int cyc;
    for (int i = 0; i < 64; i++) begin
      a = {7'b0, 23'($urandom_range(0, 32'h007F_FFFF)), 2'b00};
      cpu_xfer(a, 1'b0, 32'h0, 4'h0, rd, ack, err, cyc);
      vectors++;
      if (!ack || rd !== arch(a)) begin
        miscompares++;
        $display("FAIL rand_read adr=%h got=%h required=%h", a, rd, arch(a));
      end
    end
  endtask

  task automatic test_write_merge();
    logic [31:0] a, d, rd, nw;
    logic [3:0] s;
    logic ack, err;
    int cyc;
    for (int i = 0; i < 1024; i++) begin
      a = 32'(i) * 4;
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      nw = arch(a);
      for (int b = 0; b < 4; b++) if (s[b]) nw[8*b +: 8] = d[8*b +: 8];
      cpu_xfer(a, 1'b1, d, s, rd, ack, err, cyc);
      expw[a >> 2] = nw;
      vectors++;
      if (ack !== 1'b1 || err !== 1'b0) begin
        miscompares++;
        $display("FAIL write_ack adr=%h ack=%b err=%b, required ack=1 err=0", a, ack, err);
      end
    end
    for (int i = 0; i < 1024; i++) begin
      a = 32'(i) * 4;
      cpu_xfer(a, 1'b0, 32'h0, 4'h0, rd, ack, err, cyc);
      vectors++;
      if (!ack || rd !== arch(a)) begin
        miscompares++;
        $display("FAIL write_readback adr=%h got=%h required=%h", a, rd, arch(a));
      end
    end
  endtask

  task automatic test_writeback();
    logic [31:0] rd;
    logic ack, err;
    int cyc;
    cpu_xfer(32'h0, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, ack, err, cyc);
    expw[0] = 32'hDEAD_BEEF;
    clear_log();
    cpu_xfer(32'h800, 1'b0, 32'h0, 4'h0, rd, ack, err, cyc);
    vectors++;
    if (!ack || rd !== arch(32'h800)) begin
      miscompares++;
      $display("FAIL wb_read800 got=%h required=%h", rd, arch(32'h800));
    end
    vectors++;
    if (blog_adr.size() != 2) begin
      miscompares++;
      $display("FAIL wb_burst_count got=%0d required=2", blog_adr.size());
    end else if (blog_we[0] !== 1'b1 || blog_adr[0] !== 32'h0 || blog_w0[0] !== 32'hDEAD_BEEF ||
                 blog_we[1] !== 1'b0 || blog_adr[1] !== 32'h800) begin
      miscompares++;
      $display("FAIL wb_bursts got we0=%b adr0=%h w0=%h we1=%b adr1=%h, required 1/0/deadbeef/0/800",
               blog_we[0], blog_adr[0], blog_w0[0], blog_we[1], blog_adr[1]);
    end
    cpu_xfer(32'h0, 1'b0, 32'h0, 4'h0, rd, ack, err, cyc);
    vectors++;
    if (!ack || rd !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL wb_read0 got=%h required=deadbeef", rd);
    end
  endtask

  task automatic test_error();
    logic [31:0] rd;
    logic ack, err;
    int cyc;
    clear_log();
    err_beat = 5; err_inject = 1'b1;
    cpu_xfer(32'h1000, 1'b0, 32'h0, 4'h0, rd, ack, err, cyc);
    vectors++;
    if (err !== 1'b1 || ack !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse err=%b ack=%b, required err=1 ack=0", err, ack);
    end
    @(posedge mclk); #1;
    vectors++;
    if (wb_cpu_err_o !== 1'b0 || wb_cpu_ack_o !== 1'b0 || wb_app_stb_o !== 1'b0) begin
      miscompares++;
      $display("FAIL err_single err=%b ack=%b app_stb=%b, required all 0",
               wb_cpu_err_o, wb_cpu_ack_o, wb_app_stb_o);
    end
    err_inject = 1'b0;
    clear_log();
    cpu_xfer(32'h10, 1'b0, 32'h0, 4'h0, rd, ack, err, cyc);
    vectors++;
    if (!ack || rd !== arch(32'h10) || blog_adr.size() != 1) begin
      miscompares++;
      $display("FAIL err_invalidate got=%h bursts=%0d, required=%h bursts=1",
               rd, blog_adr.size(), arch(32'h10));
    end
    clear_log();
    cpu_xfer(32'h1000, 1'b0, 32'h0, 4'h0, rd, ack, err, cyc);
    vectors++;
    if (!ack || err || rd !== arch(32'h1000) || blog_adr.size() != 1) begin
      miscompares++;
      $display("FAIL err_retry got=%h ack=%b bursts=%0d, required=%h ack=1 bursts=1",
               rd, ack, blog_adr.size(), arch(32'h1000));
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    repeat (2) @(posedge mclk);
    #1;
    cpu_stb = 1'b1; cpu_adr = 32'h1004; cpu_we = 1'b0;
    cyc = 0;
    while (wb_cpu_ack_o !== 1'b1 && cyc < 20) begin @(posedge mclk); #1; cyc++; end
    vectors++;
    if (cyc != 3 || wb_cpu_dat_o !== arch(32'h1004)) begin
      miscompares++;
      $display("FAIL b2b_first latency=%0d got=%h, required latency=3 data=%h",
               cyc, wb_cpu_dat_o, arch(32'h1004));
    end
    // Strobe stays high through the edge after ack, then a new address follows.
    @(posedge mclk); #1;
    vectors++;
    if (wb_cpu_ack_o !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_turn ack=%b, required 0", wb_cpu_ack_o);
    end
    cpu_adr = 32'h1008;
    cyc = 0;
    while (wb_cpu_ack_o !== 1'b1 && cyc < 20) begin @(posedge mclk); #1; cyc++; end
    vectors++;
    if (cyc != 4 || wb_cpu_dat_o !== arch(32'h1008)) begin
      miscompares++;
      $display("FAIL b2b_second latency=%0d got=%h, required latency=4 data=%h",
               cyc, wb_cpu_dat_o, arch(32'h1008));
    end
    cpu_stb = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] rd;
    logic ack, err;
    int cyc;
    repeat (2) @(posedge mclk);
    #1;
    cpu_stb = 1'b1; cpu_adr = 32'h2000; cpu_we = 1'b0;
    cyc = 0;
    while (wb_app_stb_o !== 1'b1 && cyc < 50) begin @(posedge mclk); #1; cyc++; end
    if (wb_app_stb_o !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL rstmid_no_burst app_stb=%b after %0d cycles, required 1", wb_app_stb_o, cyc);
    end
    repeat (3) @(posedge mclk);
    #1;
    rst_n = 1'b0;
    @(posedge mclk); #1;
    vectors++;
    if ({wb_cpu_ack_o, wb_cpu_err_o, wb_cpu_dat_o, wb_app_stb_o, wb_app_adr_o, wb_app_we_o,
         wb_app_dat_o, wb_app_sel_o, wb_app_bl_o} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_outputs stb=%b adr=%h sel=%h bl=%0d, all required 0",
               wb_app_stb_o, wb_app_adr_o, wb_app_sel_o, wb_app_bl_o);
    end
    cpu_stb = 1'b0;
    @(posedge mclk); #1;
    rst_n = 1'b1;
    clear_log();
    cpu_xfer(32'h1000, 1'b0, 32'h0, 4'h0, rd, ack, err, cyc);
    vectors++;
    if (!ack || rd !== arch(32'h1000) || blog_adr.size() != 1) begin
      miscompares++;
      $display("FAIL rstmid_miss got=%h bursts=%0d, required=%h bursts=1",
               rd, blog_adr.size(), arch(32'h1000));
    end
  endtask

  initial begin
    test_reset();
    test_seq_read();
    test_random_read();
    test_write_merge();
    test_writeback();
    test_error();
    test_back_to_back();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
